hilo_muldiv: RTL and testbench

- Multi-cycle multiply/divide unit for the MIPS32 pipeline. It executes MULT, MULTU, DIV and DIVU, and it is the sole writer of the HI/LO register pair.
- It sits beside the execute stage and is started by the EX-stage instruction.
- While an operation is in flight it asserts a stall request that freezes the front of the pipeline.
- On completion it emits a one-cycle HI/LO write pulse. The existing HI/LO register and execute path consume that value (MFHI/MFLO read it).

---
 rtl/hilo_muldiv_pkg.sv | 32 +++
 rtl/hilo_muldiv_div_iter_core.sv | 66 ++++++
 rtl/hilo_muldiv.sv | 148 ++++++++++++++
 tb/tb_hilo_muldiv.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
// Op codes and state encodings match the pipeline's existing definitions.
package hilo_muldiv_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } mdu_state_e;

    localparam logic [31:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF;

    // Even-coded ops (MULT, DIV) are the signed variants.
    function automatic logic is_signed_op(input mdu_op_e op);
        return ~op[0];
    endfunction

    // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] abs_mag(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/hilo_muldiv_div_iter_core.sv
// Radix-2 restoring divider datapath: one quotient bit per step, MSB first.
// The quotient register starts out holding the dividend and shifts it out as quotient bits shift in.
module hilo_muldiv_div_iter_core #(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        last
);

    localparam int CNT_W = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;

    logic [31:0]      rem_q, rem_d;
    logic [31:0]      quot_q, quot_d;
    logic [31:0]      divisor_q, divisor_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [32:0]      partial;
    logic [32:0]      trial;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        rem_d     = rem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        partial   = {rem_q, quot_q[31]};
        trial     = partial - {1'b0, divisor_q};
        if (load) begin
            rem_d     = '0;
            quot_d    = dividend;
            divisor_d = divisor;
            cnt_d     = '0;
        end else if (step) begin
            // A clear borrow means the divisor fits; the difference is always below 2^32.
            rem_d  = trial[32] ? partial[31:0] : trial[31:0];
            quot_d = {quot_q[30:0], ~trial[32]};
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
        end else begin
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign last      = (cnt_q == CNT_W'(DIV_ITER - 1));

endmodule

// File: rtl/hilo_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit; sole writer of HI/LO.
// It stalls the front of the pipeline while busy and releases the stall in the cycle of the write.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  mdu_op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    output logic        busy,
    output logic        stall_req,
    output logic        hilo_we,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    mdu_state_e  state_q, state_d;
    mdu_op_e     op_q, op_d;
    mdu_op_e     op_in;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        a_neg_q, a_neg_d;
    logic        b_neg_q, b_neg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        accept;
    logic        div_load;
    logic [31:0] div_quot;
    logic [31:0] div_rem;
    logic        div_last;
    logic [32:0] mul_a_ext;
    logic [32:0] mul_b_ext;
    logic [63:0] product;

    assign op_in    = mdu_op_e'(mdu_op);
    assign accept   = (state_q == S_IDLE) && start && !flush;
    assign div_load = accept && op_in[1] && (src2 != 32'd0);

    hilo_muldiv_div_iter_core #(
        .DIV_ITER (DIV_ITER)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load),
        .step      (state_q == S_DIV),
        .dividend  (is_signed_op(op_in) ? abs_mag(src1) : src1),
        .divisor   (is_signed_op(op_in) ? abs_mag(src2) : src2),
        .quotient  (div_quot),
        .remainder (div_rem),
        .last      (div_last)
    );

    // 33-bit extension lets one signed multiplier serve both MULT and MULTU.
    assign mul_a_ext = {(op_q == MDU_MULT) & a_q[31], a_q};
    assign mul_b_ext = {(op_q == MDU_MULT) & b_q[31], b_q};
    assign product   = $signed({{31{mul_a_ext[32]}}, mul_a_ext}) *
                       $signed({{31{mul_b_ext[32]}}, mul_b_ext});

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = op_in;
                    a_d     = src1;
                    b_d     = src2;
                    a_neg_d = is_signed_op(op_in) & src1[31];
                    b_neg_d = is_signed_op(op_in) & src2[31];
                    if (!op_in[1]) begin
                        state_d = S_MUL;
                    end else if (src2 != 32'd0) begin
                        state_d = S_DIV;
                    end else begin
                        state_d = S_DONE;
                        hi_d    = src1;
                        lo_d    = DIV_BY_ZERO_LO;
                    end
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d      = S_DONE;
                    {hi_d, lo_d} = product;
                end
            end
            S_DIV: begin
                if (flush)         state_d = S_IDLE;
                else if (div_last) state_d = S_FIX;
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    // Quotient sign is the XOR of operand signs; remainder follows the dividend.
                    state_d = S_DONE;
                    lo_d    = (a_neg_q ^ b_neg_q) ? (~div_quot + 32'd1) : div_quot;
                    hi_d    = a_neg_q ? (~div_rem + 32'd1) : div_rem;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= MDU_MULT;
            a_q     <= '0;
            b_q     <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign hilo_we   = (state_q == S_DONE) && !flush;
    assign stall_req = accept || ((state_q != S_IDLE) && (state_q != S_DONE));
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: expected HI/LO and write cycle are queued at issue
// and checked by a monitor whenever hilo_we fires.
module tb_hilo_muldiv;

    localparam int DIV_ITER = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mdu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        busy;
    logic        stall_req;
    logic        hilo_we;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    hilo_muldiv #(
        .DIV_ITER (DIV_ITER)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mdu_op    (mdu_op),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .busy      (busy),
        .stall_req (stall_req),
        .hilo_we   (hilo_we),
        .hi_out    (hi_out),
        .lo_out    (lo_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    // Monitor: every write must match the oldest outstanding expectation, in value and cycle.
    always @(negedge clk) begin
        if (!rst && hilo_we) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write at cycle %0d: hi=%h lo=%h, no write was expected", cyc, hi_out, lo_out);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if (hi_out !== mon_e.hi) begin
                    errors++;
                    $display("FAIL hi_value: got %h, expected %h", hi_out, mon_e.hi);
                end
                checks++;
                if (lo_out !== mon_e.lo) begin
                    errors++;
                    $display("FAIL lo_value: got %h, expected %h", lo_out, mon_e.lo);
                end
                checks++;
                if (cyc !== mon_e.due) begin
                    errors++;
                    $display("FAIL write_cycle: got %0d, expected %0d", cyc, mon_e.due);
                end
                checks++;
                if (stall_req !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_done: got %b, expected 0", stall_req);
                end
            end
        end
    end

    function automatic logic [63:0] mul_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        if (op == 2'd0) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return p;
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    function automatic logic [63:0] div_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint q;
        longint r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == 2'd2) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Called just after a negedge; returns just after the following negedge with start dropped.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int lat);
        exp_t e;
        e.hi  = exp_hi;
        e.lo  = exp_lo;
        e.due = cyc + lat;
        sb.push_back(e);
        start  = 1'b1;
        mdu_op = op;
        src1   = a;
        src2   = b;
        #1;
        checks++;
        if (stall_req !== 1'b1) begin
            errors++;
            $display("FAIL stall_on_accept: got %b, expected 1", stall_req);
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (lat > 1) begin
            checks++;
            if (stall_req !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_while_busy: stall=%b busy=%b, expected 1 1", stall_req, busy);
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL timeout_%s: still busy=%b pending=%0d after 100 cycles", tag, busy, sb.size());
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] r;
        int          lat;
        if (op[1]) begin
            r   = div_model(op, a, b);
            lat = (b == 32'd0) ? 1 : DIV_ITER + 2;
        end else begin
            r   = mul_model(op, a, b);
            lat = 2;
        end
        issue(op, a, b, r[63:32], r[31:0], lat);
        wait_idle(tag);
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        mdu_op = 2'd0;
        src1   = '0;
        src2   = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, hilo_we, stall_req, hi_out, lo_out} !== 67'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b we=%b stall=%b hi=%h lo=%h, expected all 0",
                     busy, hilo_we, stall_req, hi_out, lo_out);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        issue(2'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 2);
        wait_idle("mult_neg3x5");
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2);
        wait_idle("multu_max");
        issue(2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 2);
        wait_idle("mult_minsq");
        for (int i = 0; i < 4; i++) begin
            run_op(2'(i % 2), $urandom, $urandom, "mult_rand");
        end
    endtask

    task automatic test_div();
        issue(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_ITER + 2);
        wait_idle("div_neg7by2");
        issue(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, DIV_ITER + 2);
        wait_idle("divu_100by7");
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_ITER + 2);
        wait_idle("div_overflow");
        for (int i = 0; i < 4; i++) begin
            logic [31:0] d;
            d = $urandom;
            if (i == 3) d = {16'd0, d[15:0]};
            if (d == 32'd0) d = 32'd3;
            run_op(2'd2 + 2'(i % 2), $urandom, d, "div_rand");
        end
    endtask

    task automatic test_div_by_zero();
        issue(2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1);
        wait_idle("divu_by_zero");
        issue(2'd2, 32'h8000_0000, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        wait_idle("div_by_zero");
    endtask

    task automatic test_flush();
        // Divide aborted mid-iteration: the monitor rejects any write, since nothing is queued.
        start  = 1'b1;
        mdu_op = 2'd2;
        src1   = 32'd1000;
        src2   = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || stall_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_div: busy=%b stall=%b, expected 0 0", busy, stall_req);
        end
        @(negedge clk);
        issue(2'd0, 32'd7, 32'd6, 32'd0, 32'd42, 2);
        wait_idle("mult_after_flush");

        // Flush landing in DONE suppresses the write.
        start  = 1'b1;
        mdu_op = 2'd1;
        src1   = 32'd9;
        src2   = 32'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1 flush = 1'b1;
        #1;
        checks++;
        if (hilo_we !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_done: we=%b busy=%b, expected 0 1", hilo_we, busy);
        end
        @(posedge clk);
        #1 flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_done_idle: busy=%b, expected 0", busy);
        end
        @(negedge clk);

        // Start together with flush in IDLE is ignored.
        start = 1'b1;
        flush = 1'b1;
        #1;
        checks++;
        if (stall_req !== 1'b0) begin
            errors++;
            $display("FAIL start_flush_stall: got %b, expected 0", stall_req);
        end
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_flush_busy: got %b, expected 0", busy);
        end
    endtask

    task automatic test_busy_start();
        issue(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, DIV_ITER + 2);
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            mdu_op = 2'($urandom);
            src1   = $urandom;
            src2   = $urandom;
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle("busy_start");
    endtask

    task automatic test_reset_mid();
        issue(2'd2, 32'hDEAD_BEEF, 32'd17, 32'd0, 32'd0, DIV_ITER + 2);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, hilo_we, hi_out, lo_out} !== 66'd0) begin
            errors++;
            $display("FAIL reset_mid_div: busy=%b we=%b hi=%h lo=%h, expected all 0",
                     busy, hilo_we, hi_out, lo_out);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        run_op(2'd0, 32'h1234_5678, 32'hFEDC_BA98, "b2b_mult");
        run_op(2'd3, 32'hFFFF_FFFF, 32'd10, "b2b_divu");
        run_op(2'd1, 32'hABCD_0123, 32'd2, "b2b_multu");
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_by_zero();
        test_flush();
        test_busy_start();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
